icache_ctrl: RTL and testbench

//  2-way set-associative instruction-cache controller between IF stage and memory bus.

---
 rtl/icache_ctrl_pkg.sv | 25 ++
 rtl/icache_lru_tbl.sv | 29 ++
 rtl/icache_ctrl.sv | 177 +++++++++++++++++
 tb/tb_icache_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the 2-way instruction-cache controller.
// The line layout and controller states are shared with the LRU sub-module.
package icache_ctrl_pkg;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_WRITE
    } state_t;

    // Word 0 is bits [31:0], word 3 is bits [127:96].
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel);
        return line[WORD_W*sel +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_lru_tbl.sv
// Per-set replacement bit: names the way to evict next in that set.
// The table clears on reset, reads asynchronously and has one write port.
module icache_lru_tbl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [INDEX_W-1:0] i_raddr,
    output logic               o_rdata,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_waddr,
    input  logic               i_wdata
);

    logic [2**INDEX_W-1:0] r_bits;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_bits <= '0;
        end else if (i_we) begin
            r_bits[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_bits[i_raddr];

endmodule

// File: rtl/icache_ctrl.sv
// 2-way set-associative I-cache controller: invalidation sweep, lookup,
// 4-beat line refill and forwarding of the requested word on refill.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 28 - INDEX_W
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_pc_valid,
    input  logic [31:0]              i_pc,
    output logic                     o_pc_ready,
    output logic                     o_inst_valid,
    output logic [31:0]              o_inst,
    output logic [INDEX_W-1:0]       o_ram_addr,
    input  logic [2*(TAG_W+1)-1:0]   i_tagv_rdata,
    input  logic [2*LINE_W-1:0]      i_data_rdata,
    output logic [1:0]               o_ram_we,
    output logic [TAG_W:0]           o_tagv_wdata,
    output logic [LINE_W-1:0]        o_data_wdata,
    output logic                     o_rd_req,
    output logic [31:0]              o_rd_addr,
    input  logic                     i_rd_rdy,
    input  logic                     i_ret_valid,
    input  logic                     i_ret_last,
    input  logic [31:0]              i_ret_data
);

    localparam int TAGV_W = TAG_W + 1;

    state_t              r_state, w_next;
    logic [INDEX_W-1:0]  r_cnt;
    logic [31:0]         r_pc;
    logic [1:0]          r_beat;
    logic [LINE_W-1:0]   r_line;
    logic [1:0]          r_vld;

    logic [TAG_W-1:0]    w_pc_tag, w_tag0, w_tag1;
    logic [INDEX_W-1:0]  w_pc_idx, w_in_idx;
    logic                w_v0, w_v1, w_hit0, w_hit1, w_hit, w_hit_way;
    logic [LINE_W-1:0]   w_hit_line;
    logic                w_victim, w_lru;
    logic                w_lru_we, w_lru_wdata, w_accept;
    logic                w_unused;

    assign w_pc_tag = r_pc[31 -: TAG_W];
    assign w_pc_idx = r_pc[OFFSET_W +: INDEX_W];
    assign w_in_idx = i_pc[OFFSET_W +: INDEX_W];
    assign w_unused = ^r_pc[1:0];

    assign w_tag0 = i_tagv_rdata[TAG_W-1:0];
    assign w_v0   = i_tagv_rdata[TAG_W];
    assign w_tag1 = i_tagv_rdata[TAGV_W +: TAG_W];
    assign w_v1   = i_tagv_rdata[2*TAGV_W-1];

    assign w_hit0     = w_v0 && (w_tag0 == w_pc_tag);
    assign w_hit1     = w_v1 && (w_tag1 == w_pc_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = ~w_hit0;
    assign w_hit_line = w_hit0 ? i_data_rdata[LINE_W-1:0] : i_data_rdata[2*LINE_W-1:LINE_W];

    // Fill an empty way first; only a full set consults the LRU bit.
    assign w_victim = !r_vld[0] ? 1'b0 : (!r_vld[1] ? 1'b1 : w_lru);

    assign o_rd_addr = {r_pc[31:OFFSET_W], {OFFSET_W{1'b0}}};

    icache_lru_tbl #(.INDEX_W(INDEX_W)) u_lru (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_raddr (w_pc_idx),
        .o_rdata (w_lru),
        .i_we    (w_lru_we),
        .i_waddr (w_pc_idx),
        .i_wdata (w_lru_wdata)
    );

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_lru_we     = 1'b0;
        w_lru_wdata  = 1'b0;
        o_pc_ready   = 1'b0;
        o_inst_valid = 1'b0;
        o_inst       = '0;
        o_ram_addr   = w_pc_idx;
        o_ram_we     = 2'b00;
        o_tagv_wdata = '0;
        o_data_wdata = r_line;
        o_rd_req     = 1'b0;
        case (r_state)
            S_INIT: begin
                o_ram_addr = r_cnt;
                o_ram_we   = 2'b11;
                if (&r_cnt) w_next = S_IDLE;
            end
            S_IDLE: begin
                o_pc_ready = 1'b1;
                o_ram_addr = w_in_idx;
                if (i_pc_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    o_inst_valid = 1'b1;
                    o_inst       = word_sel(w_hit_line, r_pc[3:2]);
                    w_lru_we     = 1'b1;
                    w_lru_wdata  = ~w_hit_way;
                    o_pc_ready   = 1'b1;
                    // A request accepted alongside a hit is looked up next cycle.
                    if (i_pc_valid) begin
                        w_accept   = 1'b1;
                        o_ram_addr = w_in_idx;
                        w_next     = S_LOOKUP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_next = S_MISS;
                end
            end
            S_MISS: begin
                o_rd_req = 1'b1;
                if (i_rd_rdy) w_next = S_REFILL;
            end
            S_REFILL: begin
                if (i_ret_valid && i_ret_last) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_ram_we     = w_victim ? 2'b10 : 2'b01;
                o_tagv_wdata = {1'b1, w_pc_tag};
                o_inst_valid = 1'b1;
                o_inst       = word_sel(r_line, r_pc[3:2]);
                w_lru_we     = 1'b1;
                w_lru_wdata  = ~w_victim;
                w_next       = S_IDLE;
            end
            default: w_next = S_INIT;
        endcase
        // While reset is held, nothing leaves the block and no state advances.
        if (!i_rstn) begin
            w_next       = S_INIT;
            w_accept     = 1'b0;
            w_lru_we     = 1'b0;
            o_pc_ready   = 1'b0;
            o_inst_valid = 1'b0;
            o_inst       = '0;
            o_ram_we     = 2'b00;
            o_rd_req     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_beat  <= '0;
            r_line  <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
            if (w_accept) r_pc <= i_pc;
            // Way validity is captured at the miss and held for victim choice.
            if (r_state == S_LOOKUP && !w_hit) r_vld <= {w_v1, w_v0};
            if (r_state == S_MISS && i_rd_rdy) r_beat <= '0;
            if (r_state == S_REFILL && i_ret_valid) begin
                r_line[WORD_W*r_beat +: WORD_W] <= i_ret_data;
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: RAM and bus models plus an inst scoreboard.
module tb_icache_ctrl;

    localparam int INDEX_W = 8;
    localparam int TAG_W   = 20;
    localparam int TAGV_W  = TAG_W + 1;

    logic                clk = 1'b0;
    logic                rstn, pc_valid, pc_ready, inst_valid;
    logic [31:0]         pc, inst, rd_addr, ret_data;
    logic [INDEX_W-1:0]  ram_addr;
    logic [2*TAGV_W-1:0] tagv_rdata;
    logic [255:0]        data_rdata;
    logic [1:0]          ram_we;
    logic [TAGV_W-1:0]   tagv_wdata;
    logic [127:0]        data_wdata;
    logic                rd_req, rd_rdy, ret_valid, ret_last;

    always #5 clk = ~clk;

    icache_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_pc_valid   (pc_valid),
        .i_pc         (pc),
        .o_pc_ready   (pc_ready),
        .o_inst_valid (inst_valid),
        .o_inst       (inst),
        .o_ram_addr   (ram_addr),
        .i_tagv_rdata (tagv_rdata),
        .i_data_rdata (data_rdata),
        .o_ram_we     (ram_we),
        .o_tagv_wdata (tagv_wdata),
        .o_data_wdata (data_wdata),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .i_rd_rdy     (rd_rdy),
        .i_ret_valid  (ret_valid),
        .i_ret_last   (ret_last),
        .i_ret_data   (ret_data)
    );

    // Sync-read tag/data RAMs, one per way
    logic [TAGV_W-1:0] tagv_mem0 [0:255];
    logic [TAGV_W-1:0] tagv_mem1 [0:255];
    logic [127:0]      data_mem0 [0:255];
    logic [127:0]      data_mem1 [0:255];

    always @(posedge clk) begin
        if (ram_we[0]) begin
            tagv_mem0[ram_addr] <= tagv_wdata;
            data_mem0[ram_addr] <= data_wdata;
        end
        if (ram_we[1]) begin
            tagv_mem1[ram_addr] <= tagv_wdata;
            data_mem1[ram_addr] <= data_wdata;
        end
        tagv_rdata <= {tagv_mem1[ram_addr], tagv_mem0[ram_addr]};
        data_rdata <= {data_mem1[ram_addr], data_mem0[ram_addr]};
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdq_cycles = 0;
    int          stalls = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every inst_valid pulse consumes one expected word
    always @(negedge clk) begin
        if (rd_req) rdq_cycles++;
        if (inst_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_inst: got %0h expected none", inst);
            end else begin
                mon_e = exp_q.pop_front();
                chk("inst", inst, mon_e);
            end
        end
    end

    task automatic sweep();
        int bad = 0;
        rstn = 1'b1;
        #1;
        for (int k = 0; k < 256; k++) begin
            if (pc_ready !== 1'b0 || ram_we !== 2'b11 || tagv_wdata !== '0 || ram_addr !== 8'(k))
                bad++;
            @(negedge clk);
            #1;
        end
        chk("sweep_bad_cycles", bad, 0);
        chk("sweep_done_pc_ready", pc_ready, 1'b1);
    endtask

    task automatic issue(input logic [31:0] a);
        bit done = 0;
        pc_valid = 1'b1;
        pc = a;
        for (int t = 0; t < 64 && !done; t++) begin
            if (pc_ready) done = 1;
            else stalls++;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got no accept expected accept of %0h", a);
        end
    endtask

    task automatic serve(input logic [31:0] exp_addr, input int rdy_dly, input int gap,
                         input logic [31:0] base, input logic [1:0] exp_we,
                         input logic [19:0] exp_tag, input int rst_beat);
        bit seen = 0;
        int bad = 0;
        for (int t = 0; t < 64 && !seen; t++) begin
            if (rd_req) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_req_timeout: got no rd_req expected rd_req for %0h", exp_addr);
            return;
        end
        chk("rd_addr", rd_addr, exp_addr);
        repeat (rdy_dly) begin
            @(negedge clk);
            if (rd_req !== 1'b1 || rd_addr !== exp_addr) bad++;
        end
        if (rdy_dly > 0) chk("rd_hold_stable", bad, 0);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                ret_valid = 1'b0;
                ret_data  = 32'hDEAD_BEEF;
                @(negedge clk);
            end
            ret_valid = 1'b1;
            ret_data  = base + 32'(i);
            ret_last  = (i == 3);
            if (i == rst_beat) begin
                rstn = 1'b0;
                @(negedge clk);
                ret_valid = 1'b0;
                ret_last  = 1'b0;
                chk("rst_mid_inst_valid", inst_valid, 1'b0);
                chk("rst_mid_rd_req", rd_req, 1'b0);
                chk("rst_mid_pc_ready", pc_ready, 1'b0);
                return;
            end
            @(negedge clk);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        chk("write_we", ram_we, exp_we);
        chk("write_tagv", tagv_wdata, {1'b1, exp_tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rstn = 1'b0; pc_valid = 1'b0; pc = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_pc_ready", pc_ready, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_ram_we", ram_we, 2'b00);
        sweep();

        // Cold miss into empty set 0: way0 filled, word 2 forwarded
        issue(32'h1C00_0008);
        pc_valid = 1'b0;
        exp_q.push_back(32'hA2);
        serve(32'h1C00_0000, 0, 0, 32'hA0, 2'b01, 20'h1C000, -1);
        @(negedge clk);

        // Same line back-to-back: four hits, no stall, no bus request
        r0 = rdq_cycles;
        stalls = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        issue(32'h1C00_0000);
        issue(32'h1C00_0004);
        issue(32'h1C00_0008);
        issue(32'h1C00_000C);
        pc_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("burst_stalls", stalls, 0);
        chk("burst_rd_req_cycles", rdq_cycles - r0, 0);

        // Second tag in set 0 goes to empty way1; slow bus and gapped beats
        issue(32'h2C00_0000);
        pc_valid = 1'b0;
        exp_q.push_back(32'hB0);
        serve(32'h2C00_0000, 5, 1, 32'hB0, 2'b10, 20'h2C000, -1);
        @(negedge clk);

        // Hit way0, then third tag evicts way1 (the LRU way)
        r0 = rdq_cycles;
        exp_q.push_back(32'hA3);
        issue(32'h1C00_000C);
        exp_q.push_back(32'hC1);
        issue(32'h3C00_0004);
        pc_valid = 1'b0;
        chk("lru_hit_no_rd_req", rdq_cycles - r0, 0);
        serve(32'h3C00_0000, 0, 0, 32'hC0, 2'b10, 20'h3C000, -1);
        @(negedge clk);

        // Retained way0 and new way1 both hit
        r0 = rdq_cycles;
        exp_q.push_back(32'hA1);
        issue(32'h1C00_0004);
        exp_q.push_back(32'hC3);
        issue(32'h3C00_000C);
        pc_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rehit_no_rd_req", rdq_cycles - r0, 0);

        // Reset during beat 2 of a refill, then a full sweep again
        issue(32'h1C00_0010);
        pc_valid = 1'b0;
        serve(32'h1C00_0010, 0, 1, 32'hD0, 2'b01, 20'h1C000, 2);
        @(negedge clk);
        sweep();

        // Sweep invalidated the cache: previously cached line misses again
        exp_q.push_back(32'hE2);
        issue(32'h1C00_0008);
        pc_valid = 1'b0;
        serve(32'h1C00_0000, 0, 0, 32'hE0, 2'b01, 20'h1C000, -1);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
